udp_axis_frame_gen: RTL and testbench
=====================================

# udp_axis_frame_gen

Parametrised IPv4/UDP packet generator with an AXI-stream byte output, matching the `axisIn_*` channel that `RxTop` consumes. On a start pulse it emits one complete IPv4+UDP packet (no Ethernet header):

- 20-byte IP header with the checksum computed in hardware.
- 8-byte UDP header.
- Payload taken from an internal counting pattern or a pass-through input stream.
- Zero padding up to the Ethernet minimum.

It replaces hand-written frame stimulus for `RxTop` bring-up, and also serves as the on-chip packet source.

## Interface
Parameters:
- SRC_IP, 32'hC0A80141: IP source address.
- DST_IP, 32'hC0A80180: IP destination address.
- SRC_PORT, 16'd1234: UDP source port.
- DST_PORT, 16'd1234: UDP destination port.
- TTL, 8'd64: IP time-to-live.
- ID_INIT, 16'h0000: identification value of the first packet after reset.
- MAX_LEN, 1472: largest accepted payload length in bytes.
- LEN_W, 11: width of the length input.

Ports:
- sys_clk  in  1  single clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- startLen  in  LEN_W  payload length in bytes, sampled with start
- startMode  in  1  0 = counting pattern, 1 = pass-through from payloadIn; sampled with start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the final output handshake
- err  out  1  one-cycle pulse when start is rejected
- payloadIn_valid  in  1  pass-through payload valid
- payloadIn_ready  out  1  pass-through payload ready
- payloadIn_payload_data  in  8  pass-through payload byte
- axisOut_valid  out  1  output valid
- axisOut_ready  in  1  output ready
- axisOut_payload_data  out  8  output byte
- axisOut_payload_last  out  1  high on the final byte of the packet, padding included
- axisOut_payload_user  out  1  high on the first byte of the packet (0x45)

## Operation
**States.** IDLE → CSUM → HDR → PAY → PAD → IDLE. PAY is skipped when len = 0. PAD is skipped when len ≥ 18.

**IDLE.**
- start with startLen ≤ MAX_LEN: latch len and mode, set busy, go to CSUM.
- start with startLen > MAX_LEN: pulse err, stay in IDLE, busy stays 0.

**CSUM (2 cycles).**
- Cycle 1 forms the 32-bit one's-complement sum of the nine header words: 0x4500, len+28, ID, 0x0000, {TTL,0x11}, SRC_IP[31:16], SRC_IP[15:0], DST_IP[31:16], DST_IP[15:0].
- Cycle 2 folds the carries twice and inverts.

**HDR.** 28 bytes, big-endian, in this order:
- 45 00, len+28, ID, 00 00, TTL, 11, checksum, SRC_IP, DST_IP.
- SRC_PORT, DST_PORT, len+8, 00 00. The UDP checksum is always 0.

**PAY.**
- Mode 0: byte k = k[7:0].
- Mode 1: payloadIn_ready = axisOut_ready while in PAY, otherwise 0. axisOut_valid = payloadIn_valid, and the data passes straight through. payloadIn_ready stays 0 outside PAY.

**PAD.** 18−len zero bytes.

**Length fields.**
- The IP total length and UDP length fields carry the unpadded length.
- The bytes on the wire number max(len,18)+28.

**Identification.** Increments by 1 (mod 2^16) when done pulses. It wraps from 0xFFFF to 0x0000.

**Mid-packet reset.** All state clears, ID returns to ID_INIT, and the partial packet is abandoned.

## Timing
Reset values:
- All outputs are 0.
- The state is IDLE and ID = ID_INIT.

Latency: start in cycle 0 → axisOut_valid high in cycle 3, carrying byte 0x45 with user=1.

Handshakes:
- A transfer occurs when valid & ready.
- Once axisOut_valid is high it stays high, with data, last and user stable, until accepted. The one exception is PAY in mode 1, where valid follows payloadIn_valid combinationally.
- Sustained throughput is 1 byte/cycle when ready=1.

done and busy:
- done pulses in the cycle after the last-byte handshake; busy falls in that same cycle.
- A new start is accepted in the done cycle at the earliest; start while busy=1 is ignored with no err.

Corner cases:
- len = 18: there is no PAD state, and last is on payload byte 17.
- len = 0: last is on the 18th pad byte.
- Output registers are always used; no combinational path from axisOut_ready to axisOut_valid, except the mode-1 pass-through.

## Structure
- Package `udp_gen_pkg` holds:
  - the state enum;
  - the constants IPV4_VER_IHL=16'h4500, PROTO_UDP=8'd17, HDR_BYTES=28, MIN_PAYLOAD=18;
  - the header byte-offset constants.
- One sub-module, `ip_csum16`: a registered one's-complement accumulate, fold and invert over 9 words, 2-cycle latency.
- The top level contains the FSM, the byte counter (LEN_W+1 bits), the header mux and the ID register.

## Test plan
1. ID_INIT=16'h48E2, start len=512, mode 0, ready=1 → 540 bytes. The header has total length 0x021C, ID 48E2, checksum 0xABDD and UDP length 0x0208. Payload bytes run 00..FF,00..FF; last is on byte 539; done follows.
2. Immediately after case 1, start len=3 → ID 48E3, checksum 0xADD9, total length 0x001F. The packet is 28+3+15 pad = 46 bytes; last is on byte 45.
3. ID_INIT=16'h48DF, len=64, random ready with a 50% duty cycle → checksum 0xADA0. The byte sequence is identical to the ready=1 case, and data stays stable while valid & !ready.
4. Mode 1, len=20, payloadIn_valid with gaps → output equals the input bytes in order. There are no lost or duplicated bytes, and payloadIn_ready is 0 outside PAY.
5. start len=MAX_LEN+1 → err pulse with busy=0 and no output. Also: start while busy is ignored.
6. Assert sys_rst_n low mid-payload → all outputs 0 immediately. After release, the next packet uses ID = ID_INIT.

Source files
------------

// File: rtl/udp_gen_pkg.sv
// udp_gen_pkg: shared state encoding and IPv4/UDP header constants for the frame generator
package udp_gen_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CSUM, S_HDR, S_PAY, S_PAD} state_t;
  localparam logic [15:0] IPV4_VER_IHL = 16'h4500;
  localparam logic [7:0] PROTO_UDP = 8'd17;
  localparam int HDR_BYTES = 28;
  localparam int MIN_PAYLOAD = 18;
  localparam int OFF_TOT_LEN = 2;
  localparam int OFF_ID = 4;
  localparam int OFF_TTL = 8;
  localparam int OFF_CSUM = 10;
  localparam int OFF_SRC_IP = 12;
  localparam int OFF_DST_IP = 16;
  localparam int OFF_UDP = 20;
  localparam int OFF_UDP_LEN = 24;
endpackage

// File: rtl/ip_csum16.sv
// ip_csum16: registered one's-complement sum of nine 16-bit words; fold and invert one cycle later
module ip_csum16 (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [8:0][15:0] words,
  output logic [15:0]     csum
);
  logic [31:0] sum, sum_q, f1;
  logic [15:0] f2;
  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) sum = sum + 32'(words[i]);
    f1 = 32'(sum_q[15:0]) + 32'(sum_q[31:16]);
    f2 = f1[15:0] + f1[31:16];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      csum <= '0;
    end else begin
      if (en) sum_q <= sum;
      csum <= ~f2;
    end
  end
endmodule

// File: rtl/udp_axis_frame_gen.sv
// udp_axis_frame_gen: emits one IPv4+UDP packet per start as an AXI-stream byte flow, padded to 18 payload bytes
module udp_axis_frame_gen
  import udp_gen_pkg::*;
#(
  parameter logic [31:0] SRC_IP   = 32'hC0A80141,
  parameter logic [31:0] DST_IP   = 32'hC0A80180,
  parameter logic [15:0] SRC_PORT = 16'd1234,
  parameter logic [15:0] DST_PORT = 16'd1234,
  parameter logic [7:0]  TTL      = 8'd64,
  parameter logic [15:0] ID_INIT  = 16'h0000,
  parameter int          MAX_LEN  = 1472,
  parameter int          LEN_W    = 11
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] startLen,
  input  logic             startMode,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             payloadIn_valid,
  output logic             payloadIn_ready,
  input  logic [7:0]       payloadIn_payload_data,
  output logic             axisOut_valid,
  input  logic             axisOut_ready,
  output logic [7:0]       axisOut_payload_data,
  output logic             axisOut_payload_last,
  output logic             axisOut_payload_user
);
  localparam int CW = LEN_W + 1;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, last_idx, pay_end;
  logic [LEN_W-1:0] len_q;
  logic mode_q, too_long, accept, pass, fire;
  logic [15:0] id_q, csum, tot_len, udp_len;
  logic [0:HDR_BYTES-1][7:0] hdr;
  assign too_long = int'(startLen) > MAX_LEN;
  assign accept = state == S_IDLE && start && !too_long;
  assign tot_len = 16'(len_q) + 16'(HDR_BYTES);
  assign udp_len = 16'(len_q) + 16'd8;
  assign last_idx = (len_q < LEN_W'(MIN_PAYLOAD) ? CW'(MIN_PAYLOAD) : CW'(len_q)) + CW'(HDR_BYTES - 1);
  assign pay_end = CW'(len_q) + CW'(HDR_BYTES - 1);
  assign hdr = {IPV4_VER_IHL, tot_len, id_q, 16'h0000, TTL, PROTO_UDP, csum,
                SRC_IP, DST_IP, SRC_PORT, DST_PORT, udp_len, 16'h0000};
  ip_csum16 u_csum (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .en    (state == S_CSUM),
    .words ({IPV4_VER_IHL, tot_len, id_q, 16'h0000, TTL, PROTO_UDP, SRC_IP, DST_IP}),
    .csum  (csum)
  );
  // pass-through payload is the only place valid follows an input combinationally
  assign pass = state == S_PAY && mode_q;
  assign axisOut_valid = pass ? payloadIn_valid : state inside {S_HDR, S_PAY, S_PAD};
  assign axisOut_payload_data = state == S_HDR ? hdr[cnt[4:0]] :
                                state != S_PAY ? 8'h00 :
                                mode_q ? payloadIn_payload_data : cnt[7:0] - 8'(HDR_BYTES);
  assign axisOut_payload_last = state inside {S_PAY, S_PAD} && cnt == last_idx;
  assign axisOut_payload_user = state == S_HDR && cnt == '0;
  assign payloadIn_ready = pass && axisOut_ready;
  assign fire = axisOut_valid && axisOut_ready;
  assign busy = state != S_IDLE;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    case (state)
      S_IDLE: begin
        state_nxt = accept ? S_CSUM : S_IDLE;
        cnt_nxt = accept ? '0 : cnt;
      end
      S_CSUM: begin
        state_nxt = cnt[0] ? S_HDR : S_CSUM;
        cnt_nxt = cnt[0] ? '0 : cnt + 1'b1;
      end
      default: if (fire) begin
        cnt_nxt = cnt + 1'b1;
        state_nxt = axisOut_payload_last ? S_IDLE :
                    state == S_HDR && cnt == CW'(HDR_BYTES - 1) ? (len_q == '0 ? S_PAD : S_PAY) :
                    state == S_PAY && cnt == pay_end ? S_PAD : state;
      end
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      len_q <= '0;
      mode_q <= 1'b0;
      id_q <= ID_INIT;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (accept) len_q <= startLen;
      if (accept) mode_q <= startMode;
      if (fire && axisOut_payload_last) id_q <= id_q + 16'd1;
      done <= fire && axisOut_payload_last;
      err <= state == S_IDLE && start && too_long;
    end
  end
endmodule

// File: tb/tb_udp_axis_frame_gen.sv
// tb_udp_axis_frame_gen: randomized directed bench comparing the byte stream against a packet model built from the protocol rules
module tb_udp_axis_frame_gen;
  localparam logic [15:0] ID0 = 16'h48E2;
  localparam int MAXL = 1472;
  localparam int SIP = 32'hC0A80141;
  localparam int DIP = 32'hC0A80180;
  logic sys_clk = 0, sys_rst_n = 0, start = 0, startMode = 0, payloadIn_valid = 0, axisOut_ready = 0;
  logic [10:0] startLen = 0;
  logic [7:0] payloadIn_payload_data = 0;
  logic busy, done, err, payloadIn_ready, axisOut_valid, axisOut_payload_last, axisOut_payload_user;
  logic [7:0] axisOut_payload_data;
  int checks = 0, errors = 0;
  logic [15:0] exp_id;
  logic [7:0] exp_q[$], got_q[$], src_q[$];

  udp_axis_frame_gen #(.ID_INIT(ID0)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .startLen(startLen),
    .startMode(startMode), .busy(busy), .done(done), .err(err),
    .payloadIn_valid(payloadIn_valid), .payloadIn_ready(payloadIn_ready),
    .payloadIn_payload_data(payloadIn_payload_data), .axisOut_valid(axisOut_valid),
    .axisOut_ready(axisOut_ready), .axisOut_payload_data(axisOut_payload_data),
    .axisOut_payload_last(axisOut_payload_last), .axisOut_payload_user(axisOut_payload_user)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_csum(input int len, input logic [15:0] id);
    int s;
    s = 'h4500 + len + 28 + int'(id) + (64 * 256 + 17) + (SIP >>> 16 & 'hFFFF) + (SIP & 'hFFFF)
        + (DIP >>> 16 & 'hFFFF) + (DIP & 'hFFFF);
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >>> 16);
    return ~16'(s);
  endfunction

  function automatic void push16(input int v);
    exp_q.push_back(8'(v >>> 8));
    exp_q.push_back(8'(v));
  endfunction

  function automatic void build(input int len, input bit mode);
    exp_q.delete();
    push16('h4500); push16(len + 28); push16(int'(exp_id)); push16(0);
    exp_q.push_back(8'd64); exp_q.push_back(8'h11);
    push16(int'(ref_csum(len, exp_id)));
    push16(SIP >>> 16); push16(SIP); push16(DIP >>> 16); push16(DIP);
    push16(1234); push16(1234); push16(len + 8); push16(0);
    for (int k = 0; k < len; k++) exp_q.push_back(mode ? src_q[k] : 8'(k));
    for (int k = len; k < 18; k++) exp_q.push_back(8'h00);
  endfunction

  task automatic run_pkt(input int len, input bit mode, input int rdy_pct, input int vld_pct,
                         input bit poke, input int abort_at);
    int n = 0, pi = 0, cyc = 1, first = -1, total;
    bit hold = 0, done_seen = 0, pt;
    logic [10:0] prev = 0;
    src_q.delete();
    for (int k = 0; k < len; k++) src_q.push_back(8'($urandom));
    build(len, mode);
    total = exp_q.size();
    got_q.delete();
    start = 1; startLen = 11'(len); startMode = mode;
    @(negedge sys_clk);
    start = 0;
    chk("busy_on_start", 32'(busy), 1);
    while (cyc < 40 * total + 100) begin
      if (poke && cyc == 5) begin start = 1; startLen = 11'(MAXL + 1); end else start = 0;
      axisOut_ready = $urandom_range(99) < rdy_pct;
      payloadIn_valid = $urandom_range(99) < vld_pct;
      payloadIn_payload_data = pi < len ? src_q[pi] : 8'($urandom);
      #1;
      pt = mode && n >= 28 && n < 28 + len;
      if (poke && cyc == 6) chk("ignored_start_err", 32'(err), 0);
      if (n == total) begin
        chk("done_pulse", 32'(done), 1);
        chk("busy_fall", 32'(busy), 0);
        done_seen = 1;
        break;
      end
      if (n == abort_at) begin
        sys_rst_n = 0;
        #1;
        chk("reset_outputs", {busy, done, err, payloadIn_ready, axisOut_valid, axisOut_payload_last,
                              axisOut_payload_user, axisOut_payload_data}, 0);
        break;
      end
      if (axisOut_valid && first < 0) first = cyc;
      chk("in_ready", 32'(payloadIn_ready), 32'(pt && axisOut_ready));
      if (pt) chk("pt_valid", 32'(axisOut_valid), 32'(payloadIn_valid));
      if (hold && !pt) chk("hold_stable", {axisOut_valid, axisOut_payload_last, axisOut_payload_user,
                                            axisOut_payload_data}, 32'(prev));
      if (axisOut_valid && axisOut_ready) begin
        chk("data", 32'(axisOut_payload_data), 32'(exp_q[n]));
        chk("last", 32'(axisOut_payload_last), 32'(n == total - 1));
        chk("user", 32'(axisOut_payload_user), 32'(n == 0));
        got_q.push_back(axisOut_payload_data);
        if (pt) pi++;
        n++;
      end
      hold = axisOut_valid && !axisOut_ready && !pt;
      prev = {axisOut_valid, axisOut_payload_last, axisOut_payload_user, axisOut_payload_data};
      @(negedge sys_clk);
      cyc++;
    end
    if (abort_at < 0) begin
      chk("timeout", 32'(done_seen), 1);
      chk("latency", 32'(first), 3);
      chk("byte_count", 32'(n), 32'(total));
      if (done_seen) exp_id = exp_id + 16'd1;
    end
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("reset_state", {busy, done, err, payloadIn_ready, axisOut_valid, axisOut_payload_last,
                        axisOut_payload_user, axisOut_payload_data}, 0);
    sys_rst_n = 1;
    exp_id = ID0;
    @(negedge sys_clk);
    run_pkt(512, 0, 100, 100, 0, -1);
    chk("t1_csum", {got_q[10], got_q[11]}, 32'hABDD);
    chk("t1_tot_len", {got_q[2], got_q[3]}, 32'h021C);
    chk("t1_id", {got_q[4], got_q[5]}, 32'h48E2);
    chk("t1_udp_len", {got_q[24], got_q[25]}, 32'h0208);
    run_pkt(3, 0, 100, 100, 0, -1);
    chk("t2_csum", {got_q[10], got_q[11]}, 32'hADD9);
    chk("t2_tot_len", {got_q[2], got_q[3]}, 32'h001F);
    chk("t2_id", {got_q[4], got_q[5]}, 32'h48E3);
    chk("t2_size", 32'(got_q.size()), 46);
    run_pkt(64, 0, 50, 100, 1, -1);
    run_pkt(20, 1, 70, 60, 0, -1);
    run_pkt(18, 0, 80, 100, 0, -1);
    run_pkt(0, 1, 80, 50, 0, -1);
    run_pkt(17, 1, 60, 60, 0, -1);
    run_pkt(MAXL, 0, 100, 100, 0, -1);
    @(negedge sys_clk);
    start = 1; startLen = 11'(MAXL + 1); startMode = 0;
    @(negedge sys_clk);
    start = 0;
    chk("err_pulse", 32'(err), 1);
    chk("err_busy", 32'(busy), 0);
    chk("err_no_valid", 32'(axisOut_valid), 0);
    @(negedge sys_clk);
    chk("err_one_cycle", 32'(err), 0);
    chk("err_idle", {busy, axisOut_valid}, 0);
    run_pkt(100, 0, 100, 100, 0, 50);
    @(negedge sys_clk);
    sys_rst_n = 1;
    exp_id = ID0;
    @(negedge sys_clk);
    run_pkt(10, 0, 100, 100, 0, -1);
    chk("id_after_reset", {got_q[4], got_q[5]}, 32'(ID0));
    for (int r = 0; r < 4; r++)
      run_pkt(int'($urandom_range(40)), 1'($urandom_range(1)), 60, 70, 0, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
